// File: rtl/write_pkg.sv
// Shared writeback definitions: write-select bit positions and the buffered result entry.
package write_pkg;

    localparam int unsigned WSEL_PC  = 2;
    localparam int unsigned WSEL_WEN = 1;
    localparam int unsigned WSEL_F   = 0;

    localparam int unsigned WB_XLEN = 32;
    localparam int unsigned WB_RW   = 5;

    typedef struct packed {
        logic [2:0]         wsel;
        logic [WB_XLEN-1:0] pc;
        logic [WB_XLEN-1:0] data;
        logic [WB_RW-1:0]   rd;
    } wb_entry_t;

endpackage

// File: rtl/write_fifo.sv
// Per-channel synchronous FIFO of writeback entries; head entry is always visible on pop_data_o.
module write_fifo
    import write_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = wb_entry_t,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  entry_t        push_data_i,
    input  logic          pop_i,
    output entry_t        pop_data_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    // NOTE: storage is deliberately not reset; count and pointers alone decide which slots are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/write_arb.sv
// Multi-channel writeback: per-channel FIFOs, round-robin commit of one result per cycle,
// registered register-file / PC update outputs with integer x0 write suppression.
module write_arb
    import write_pkg::*;
#(
    parameter int unsigned NCH   = 3,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RW    = 5
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NCH-1:0]      in_valid,
    output logic [NCH-1:0]      in_ready,
    input  logic [3*NCH-1:0]    in_wsel,
    input  logic [XLEN*NCH-1:0] in_pc,
    input  logic [XLEN*NCH-1:0] in_data,
    input  logic [RW*NCH-1:0]   in_rd,
    input  logic                stall,
    output logic                wenable,
    output logic                fmode,
    output logic [RW-1:0]       wreg,
    output logic [XLEN-1:0]     wdata,
    output logic                pcenable,
    output logic [XLEN-1:0]     next_pc,
    output logic [NCH-1:0]      done
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef struct packed {
        logic [2:0]      wsel;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
        logic [RW-1:0]   rd;
    } entry_t;

    entry_t         push_data [NCH];
    entry_t         head      [NCH];
    entry_t         sel;
    logic [NCH-1:0] push, pop, fifo_empty, fifo_full;

    logic [PW-1:0]   rr_q, rr_d, winner;
    logic            grant;
    logic            wenable_q, wenable_d, fmode_q, fmode_d, pcenable_q, pcenable_d;
    logic [RW-1:0]   wreg_q, wreg_d;
    logic [XLEN-1:0] wdata_q, wdata_d, next_pc_q, next_pc_d;
    logic [NCH-1:0]  done_q, done_d;

    // Readiness depends only on fill level, so a full FIFO refuses even on the edge it pops.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign push_data[i] = '{wsel: in_wsel[3*i +: 3],
                                pc:   in_pc[XLEN*i +: XLEN],
                                data: in_data[XLEN*i +: XLEN],
                                rd:   in_rd[RW*i +: RW]};
        assign in_ready[i]  = rstn & ~fifo_full[i];
        assign push[i]      = in_valid[i] & in_ready[i];

        write_fifo #(
            .DEPTH   (DEPTH),
            .entry_t (entry_t)
        ) u_fifo (
            .clk         (clk),
            .rstn        (rstn),
            .push_i      (push[i]),
            .push_data_i (push_data[i]),
            .pop_i       (pop[i]),
            .pop_data_o  (head[i]),
            .count_o     (),
            .empty_o     (fifo_empty[i]),
            .full_o      (fifo_full[i])
        );
    end

    // NOTE: combinational blocks use blocking '=' with every output defaulted first so no latch is inferred;
    // only the clocked blocks use '<='.
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            int unsigned idx;
            idx = (int'(rr_q) + k) % NCH;
            if (!grant && !stall && !fifo_empty[idx]) begin
                grant  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    always_comb begin
        pop        = '0;
        rr_d       = rr_q;
        sel        = head[winner];
        wenable_d  = 1'b0;
        pcenable_d = 1'b0;
        done_d     = '0;
        fmode_d    = fmode_q;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        next_pc_d  = next_pc_q;
        if (grant) begin
            pop[winner]    = 1'b1;
            done_d[winner] = 1'b1;
            rr_d           = (winner == PW'(NCH - 1)) ? '0 : winner + 1'b1;
            // Integer x0 is hardwired zero; FP f0 is an ordinary register.
            wenable_d  = sel.wsel[WSEL_WEN] & ~(~sel.wsel[WSEL_F] & (sel.rd == '0));
            pcenable_d = sel.wsel[WSEL_PC];
            fmode_d    = sel.wsel[WSEL_F];
            wreg_d     = sel.rd;
            wdata_d    = sel.data;
            next_pc_d  = sel.pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_q       <= '0;
            wenable_q  <= 1'b0;
            fmode_q    <= 1'b0;
            pcenable_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            next_pc_q  <= '0;
            done_q     <= '0;
        end else begin
            rr_q       <= rr_d;
            wenable_q  <= wenable_d;
            fmode_q    <= fmode_d;
            pcenable_q <= pcenable_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            next_pc_q  <= next_pc_d;
            done_q     <= done_d;
        end
    end

    assign wenable  = wenable_q;
    assign fmode    = fmode_q;
    assign wreg     = wreg_q;
    assign wdata    = wdata_q;
    assign pcenable = pcenable_q;
    assign next_pc  = next_pc_q;
    assign done     = done_q;

endmodule

// File: tb/tb_write_arb.sv
// Directed bench for write_arb with a queue-based commit model checked on every falling edge.
module tb_write_arb;

    localparam int NCH   = 3;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
    localparam int RW    = 5;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NCH-1:0]      in_valid, in_ready;
    logic [3*NCH-1:0]    in_wsel;
    logic [XLEN*NCH-1:0] in_pc, in_data;
    logic [RW*NCH-1:0]   in_rd;
    logic                stall;
    logic                wenable, fmode, pcenable;
    logic [RW-1:0]       wreg;
    logic [XLEN-1:0]     wdata, next_pc;
    logic [NCH-1:0]      done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    write_arb #(.NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN), .RW(RW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_wsel  (in_wsel),
        .in_pc    (in_pc),
        .in_data  (in_data),
        .in_rd    (in_rd),
        .stall    (stall),
        .wenable  (wenable),
        .fmode    (fmode),
        .wreg     (wreg),
        .wdata    (wdata),
        .pcenable (pcenable),
        .next_pc  (next_pc),
        .done     (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one queue per channel, commit picks first non-empty channel from the pointer.
    typedef struct {
        logic [2:0]      wsel;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
        logic [RW-1:0]   rd;
    } ent_t;

    ent_t            mq [NCH][$];
    int              m_rr;
    bit              started = 0;
    logic            m_wen, m_fmode, m_pcen;
    logic [RW-1:0]   m_wreg;
    logic [XLEN-1:0] m_wdata, m_npc;
    logic [NCH-1:0]  m_done;

    always @(posedge clk) begin
        bit [NCH-1:0] rdy;
        int           w;
        ent_t         e;
        for (int i = 0; i < NCH; i++) rdy[i] = (mq[i].size() < DEPTH);
        m_wen  = 1'b0;
        m_pcen = 1'b0;
        m_done = '0;
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) mq[i].delete();
            m_rr = 0; m_fmode = 0; m_wreg = '0; m_wdata = '0; m_npc = '0;
        end else begin
            if (!stall) begin
                w = -1;
                for (int k = 0; k < NCH; k++)
                    if (w < 0 && mq[(m_rr + k) % NCH].size() != 0) w = (m_rr + k) % NCH;
                if (w >= 0) begin
                    e         = mq[w].pop_front();
                    m_done[w] = 1'b1;
                    m_wen     = e.wsel[1] && !(e.wsel[0] == 1'b0 && e.rd == 0);
                    m_pcen    = e.wsel[2];
                    m_fmode   = e.wsel[0];
                    m_wreg    = e.rd;
                    m_wdata   = e.data;
                    m_npc     = e.pc;
                    m_rr      = (w + 1) % NCH;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (in_valid[i] && rdy[i]) begin
                    e.wsel = in_wsel[3*i +: 3];
                    e.pc   = in_pc[XLEN*i +: XLEN];
                    e.data = in_data[XLEN*i +: XLEN];
                    e.rd   = in_rd[RW*i +: RW];
                    mq[i].push_back(e);
                end
            end
        end
        started = 1;
    end

    always @(negedge clk) begin
        logic [NCH-1:0] r;
        if (started) begin
            for (int i = 0; i < NCH; i++) r[i] = rstn && (mq[i].size() < DEPTH);
            check("cmp_in_ready", in_ready, r);
            check("cmp_wenable", wenable, m_wen);
            check("cmp_fmode", fmode, m_fmode);
            check("cmp_wreg", wreg, m_wreg);
            check("cmp_wdata", wdata, m_wdata);
            check("cmp_pcenable", pcenable, m_pcen);
            check("cmp_next_pc", next_pc, m_npc);
            check("cmp_done", done, m_done);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic [2:0] ws, input logic [RW-1:0] rd,
                         input logic [XLEN-1:0] d, input logic [XLEN-1:0] pc);
        in_valid[ch]            = 1'b1;
        in_wsel[3*ch +: 3]      = ws;
        in_rd[RW*ch +: RW]      = rd;
        in_data[XLEN*ch +: XLEN] = d;
        in_pc[XLEN*ch +: XLEN]  = pc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 0; stall = 0; in_valid = '0; in_wsel = '0; in_pc = '0; in_data = '0; in_rd = '0;
        tick(); tick();
        check("rst_wenable", wenable, 0);
        check("rst_pcenable", pcenable, 0);
        check("rst_wdata", wdata, 0);
        check("rst_done", done, 0);
        check("rst_ready", in_ready, 3'b000);
        rstn = 1; tick();
        check("ready_after_rst", in_ready, 3'b111);

        // Reset with ch0 holding two entries: they must never commit.
        stall = 1;
        drive(0, 3'b010, 5'd1, 32'h11, 32'h0); tick();
        drive(0, 3'b010, 5'd2, 32'h22, 32'h0); tick();
        in_valid = '0;
        check("ch0_full_ready", in_ready[0], 0);
        rstn = 0; tick();
        check("midrst_ready", in_ready, 3'b000);
        check("midrst_done", done, 0);
        rstn = 1; stall = 0; tick();
        check("release_ready", in_ready, 3'b111);
        check("discard_done0", done, 0);
        tick();
        check("discard_done1", done, 0);

        // Single push, one-edge latency.
        drive(1, 3'b010, 5'd5, 32'hDEADBEEF, 32'h0); tick();
        in_valid = '0; tick();
        check("single_wenable", wenable, 1);
        check("single_fmode", fmode, 0);
        check("single_wreg", wreg, 5);
        check("single_wdata", wdata, 32'hDEADBEEF);
        check("single_done", done, 3'b010);
        tick();
        check("single_wen_off", wenable, 0);
        check("single_done_off", done, 0);
        check("single_wdata_hold", wdata, 32'hDEADBEEF);

        // Round-robin from pointer 0, two rounds.
        rstn = 0; tick(); rstn = 1;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NCH; c++) drive(c, 3'b010, 5'(c + 1), 32'(100 * r + c), 32'h0);
            tick();
            in_valid = '0;
            tick(); check("rr_done_a", done, 3'b001);
            tick(); check("rr_done_b", done, 3'b010);
            tick(); check("rr_done_c", done, 3'b100);
        end

        // Integer x0 suppressed, FP f0 written.
        drive(0, 3'b110, 5'd0, 32'h5, 32'h100); tick();
        in_valid = '0; tick();
        check("x0_wenable", wenable, 0);
        check("x0_pcenable", pcenable, 1);
        check("x0_next_pc", next_pc, 32'h100);
        check("x0_done", done, 3'b001);
        drive(1, 3'b011, 5'd0, 32'h77, 32'h0); tick();
        in_valid = '0; tick();
        check("f0_wenable", wenable, 1);
        check("f0_fmode", fmode, 1);
        check("f0_wreg", wreg, 0);
        check("f0_done", done, 3'b010);

        // Stall fills ch2; third push refused, then drain in order.
        stall = 1;
        drive(2, 3'b010, 5'd7, 32'hA1, 32'h0); tick();
        drive(2, 3'b010, 5'd7, 32'hA2, 32'h0); tick();
        check("stall_full_ready", in_ready[2], 0);
        drive(2, 3'b010, 5'd7, 32'hA3, 32'h0); tick();
        in_valid = '0;
        check("stall_no_done", done, 0);
        stall = 0; tick();
        check("drain1_done", done, 3'b100);
        check("drain1_wdata", wdata, 32'hA1);
        tick();
        check("drain2_done", done, 3'b100);
        check("drain2_wdata", wdata, 32'hA2);
        check("drain_ready", in_ready[2], 1);
        tick();
        check("refused_no_done", done, 0);

        // Full ch0 pops while not ready; next edge push and pop coincide.
        stall = 1;
        drive(0, 3'b010, 5'd9, 32'hB1, 32'h0); tick();
        drive(0, 3'b010, 5'd9, 32'hB2, 32'h0); tick();
        check("pp_full_ready", in_ready[0], 0);
        stall = 0;
        drive(0, 3'b010, 5'd9, 32'hC0, 32'h0); tick();
        check("pp_pop1_wdata", wdata, 32'hB1);
        check("pp_pop1_ready", in_ready[0], 1);
        drive(0, 3'b010, 5'd9, 32'hD0, 32'h0); tick();
        check("pp_pop2_wdata", wdata, 32'hB2);
        check("pp_count_kept", in_ready[0], 1);
        in_valid = '0; tick();
        check("pp_pop3_wdata", wdata, 32'hD0);
        check("pp_pop3_done", done, 3'b001);
        tick();
        check("pp_idle_done", done, 0);

        // Mixed contention with periodic stall and a reset mid-traffic; model checks every cycle.
        for (int i = 0; i < 60; i++) begin
            in_valid = 3'((i * 5) % 8);
            stall    = (i % 7 == 3);
            rstn     = (i != 30);
            for (int c = 0; c < NCH; c++) begin
                in_wsel[3*c +: 3]       = 3'((i + c) % 8);
                in_rd[RW*c +: RW]       = 5'((i * 3 + c) % 4);
                in_data[XLEN*c +: XLEN] = 32'(i * 16 + c);
                in_pc[XLEN*c +: XLEN]   = 32'(i * 4 + c * 1024);
            end
            tick();
        end
        in_valid = '0; stall = 0; rstn = 1;
        for (int i = 0; i < 8; i++) tick();

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
